// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // Expected parity bit for a word zero-extended to the 9-bit maximum width.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side handshake of the UART receiver: received word, error flags
// and the valid/ready pair.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to RESET_VAL
// so an idle-high line does not look like a start bit out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling on an external oversample tick,
// optional parity, 1 or 2 stop bits, valid/ready output with overrun detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            bit_in,
  output logic            busy,
  uart_rx_param_if.master rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 fe_acc;

  logic                 half_pt;
  logic                 bit_pt;
  logic                 frame_start;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 commit;
  logic [8:0]           data_ext;
  logic                 pe_new;
  logic                 fe_new;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bit_in),
    .q     (rx_s)
  );

  assign half_pt = tick && (tick_cnt == HALF_LAST);
  assign bit_pt  = tick && (tick_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE: begin
        if (tick && !rx_s) begin
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (half_pt) begin
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_pt && (bit_cnt == DATA_LAST)) begin
          state_next = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (bit_pt) begin
          state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_pt && (bit_cnt == STOP_LAST)) begin
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  // busy drops during the last stop sample itself, so the consumer sees it
  // fall one clock before valid rises.
  always_comb begin
    busy        = 1'b0;
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    commit      = 1'b0;
    case (state)
      RX_IDLE: begin
        frame_start = tick && !rx_s;
      end
      RX_START: begin
        busy = 1'b1;
      end
      RX_DATA: begin
        busy     = 1'b1;
        shift_en = bit_pt;
      end
      RX_PARITY: begin
        busy   = 1'b1;
        par_en = bit_pt;
      end
      RX_STOP: begin
        stop_en = bit_pt;
        commit  = bit_pt && (bit_cnt == STOP_LAST);
        busy    = !commit;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Counters restart on every state change; in-state they pace the mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      fe_acc    <= 1'b0;
    end else begin
      if (state_next != state) begin
        tick_cnt <= '0;
      end else if (tick && (state != RX_IDLE)) begin
        tick_cnt <= bit_pt ? '0 : tick_cnt + 1'b1;
      end

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (shift_en || stop_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end

      if (par_en) begin
        par_bit <= rx_s;
      end

      if (frame_start) begin
        fe_acc <= 1'b0;
      end else if (stop_en && !rx_s) begin
        fe_acc <= 1'b1;
      end
    end
  end

  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = shift_reg;
  end

  assign pe_new = (PARITY_MODE == PARITY_NONE) ? 1'b0 :
                  (par_bit != parity_bit(data_ext, PARITY_MODE));
  assign fe_new = fe_acc | ~rx_s;

  // A held word blocks the commit unless it is consumed on the same clock;
  // a blocked frame is dropped and only leaves the sticky overrun behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.data_out   <= '0;
      rx_if.valid      <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end else if (commit) begin
      if (!rx_if.valid || rx_if.ready) begin
        rx_if.data_out   <= shift_reg;
        rx_if.parity_err <= pe_new;
        rx_if.frame_err  <= fe_new;
        rx_if.valid      <= 1'b1;
        if (rx_if.valid) begin
          rx_if.overrun <= 1'b0;
        end
      end else begin
        rx_if.overrun <= 1'b1;
      end
    end else if (rx_if.valid && rx_if.ready) begin
      rx_if.valid      <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: five differently configured receivers driven from
// a directed vector table, hand-written corner sequences and random frames.
module tb_uart_rx_param;

  localparam int OS = 16;
  localparam int CFG_BITS [5] = '{8, 8, 8, 8, 5};
  localparam int CFG_PAR  [5] = '{0, 1, 2, 0, 0};
  localparam int CFG_STOP [5] = '{1, 1, 1, 2, 1};

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       par_b;
    logic [1:0] stop;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [4:0] bit_in;
  logic [4:0] ready;
  wire  [4:0] busy;

  int tick_div = 1;
  int tick_cnt = 0;
  int total_cnt = 0;
  int pass_cnt = 0;

  logic v_prev = 1'b0;
  logic b_prev = 1'b0;
  logic b_prev2 = 1'b0;
  int   rise_cnt = 0;
  logic busy_rule_ok = 1'b0;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick_cnt >= tick_div - 1) tick_cnt <= 0;
    else                          tick_cnt <= tick_cnt + 1;
  end
  assign tick = (tick_cnt == 0);

  uart_rx_param_if #(.DATA_BITS(CFG_BITS[0])) if0 ();
  uart_rx_param_if #(.DATA_BITS(CFG_BITS[1])) if1 ();
  uart_rx_param_if #(.DATA_BITS(CFG_BITS[2])) if2 ();
  uart_rx_param_if #(.DATA_BITS(CFG_BITS[3])) if3 ();
  uart_rx_param_if #(.DATA_BITS(CFG_BITS[4])) if4 ();

  assign if0.ready = ready[0];
  assign if1.ready = ready[1];
  assign if2.ready = ready[2];
  assign if3.ready = ready[3];
  assign if4.ready = ready[4];

  uart_rx_param #(.DATA_BITS(CFG_BITS[0]), .OVERSAMPLE(OS), .PARITY_MODE(CFG_PAR[0]), .STOP_BITS(CFG_STOP[0]))
    u_dut0 (.clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_in[0]), .busy(busy[0]), .rx_if(if0));
  uart_rx_param #(.DATA_BITS(CFG_BITS[1]), .OVERSAMPLE(OS), .PARITY_MODE(CFG_PAR[1]), .STOP_BITS(CFG_STOP[1]))
    u_dut1 (.clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_in[1]), .busy(busy[1]), .rx_if(if1));
  uart_rx_param #(.DATA_BITS(CFG_BITS[2]), .OVERSAMPLE(OS), .PARITY_MODE(CFG_PAR[2]), .STOP_BITS(CFG_STOP[2]))
    u_dut2 (.clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_in[2]), .busy(busy[2]), .rx_if(if2));
  uart_rx_param #(.DATA_BITS(CFG_BITS[3]), .OVERSAMPLE(OS), .PARITY_MODE(CFG_PAR[3]), .STOP_BITS(CFG_STOP[3]))
    u_dut3 (.clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_in[3]), .busy(busy[3]), .rx_if(if3));
  uart_rx_param #(.DATA_BITS(CFG_BITS[4]), .OVERSAMPLE(OS), .PARITY_MODE(CFG_PAR[4]), .STOP_BITS(CFG_STOP[4]))
    u_dut4 (.clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_in[4]), .busy(busy[4]), .rx_if(if4));

  // Records how busy behaved on the two clocks before each valid rise of receiver 0.
  always @(negedge clk) begin
    v_prev  <= if0.valid;
    b_prev  <= busy[0];
    b_prev2 <= b_prev;
    if (if0.valid && !v_prev) begin
      rise_cnt     <= rise_cnt + 1;
      busy_rule_ok <= !b_prev && b_prev2;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic getOut(input int idx, output logic [8:0] d, output logic v, output logic pe,
                        output logic fe, output logic ov, output logic b);
    case (idx)
      0: begin d = 9'(if0.data_out); v = if0.valid; pe = if0.parity_err; fe = if0.frame_err; ov = if0.overrun; end
      1: begin d = 9'(if1.data_out); v = if1.valid; pe = if1.parity_err; fe = if1.frame_err; ov = if1.overrun; end
      2: begin d = 9'(if2.data_out); v = if2.valid; pe = if2.parity_err; fe = if2.frame_err; ov = if2.overrun; end
      3: begin d = 9'(if3.data_out); v = if3.valid; pe = if3.parity_err; fe = if3.frame_err; ov = if3.overrun; end
      default: begin d = 9'(if4.data_out); v = if4.valid; pe = if4.parity_err; fe = if4.frame_err; ov = if4.overrun; end
    endcase
    b = busy[idx];
  endtask

  task automatic waitTicks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
    end
    #1;
  endtask

  // Serialises one frame onto a receiver's line; abort_at >= 0 stops after that many bits.
  task automatic sendFrame(input int idx, input logic [8:0] data, input logic par_b,
                           input logic [1:0] stop, input int abort_at);
    logic seq [$];
    seq.push_back(1'b0);
    for (int i = 0; i < CFG_BITS[idx]; i++) seq.push_back(data[i]);
    if (CFG_PAR[idx] != 0) seq.push_back(par_b);
    for (int i = 0; i < CFG_STOP[idx]; i++) seq.push_back(stop[i]);
    for (int i = 0; i < seq.size(); i++) begin
      if (abort_at >= 0 && i >= abort_at) return;
      bit_in[idx] = seq[i];
      waitTicks(OS);
    end
    bit_in[idx] = 1'b1;
    waitTicks(2 * OS);
  endtask

  task automatic waitValid(input int idx, input int budget, output logic ok);
    logic [8:0] d;
    logic v, pe, fe, ov, b;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      getOut(idx, d, v, pe, fe, ov, b);
      if (v) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulseReady(input int idx);
    ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    ready[idx] = 1'b0;
  endtask

  // Frame semantics from bit counting: parity from the number of ones, framing from any low stop bit.
  function automatic void refModel(input int idx, input logic [8:0] data, input logic par_b,
                                   input logic [1:0] stop, output logic [8:0] ed,
                                   output logic epe, output logic efe);
    int ones = 0;
    ed = data & 9'((1 << CFG_BITS[idx]) - 1);
    for (int i = 0; i < CFG_BITS[idx]; i++) ones += int'(data[i]);
    ones += int'(par_b);
    case (CFG_PAR[idx])
      1:       epe = (ones % 2) != 0;
      2:       epe = (ones % 2) != 1;
      default: epe = 1'b0;
    endcase
    efe = (stop[0] == 1'b0) || (CFG_STOP[idx] == 2 && stop[1] == 1'b0);
  endfunction

  task automatic applyStimulus(input vec_t vec, input string tag);
    logic [8:0] d;
    logic v, pe, fe, ov, b, ok;
    sendFrame(vec.idx, vec.data, vec.par_b, vec.stop, -1);
    waitValid(vec.idx, 2000, ok);
    getOut(vec.idx, d, v, pe, fe, ov, b);
    checkOutput({tag, "_valid"}, 32'(ok), 32'd1);
    checkOutput({tag, "_data"}, 32'(d), 32'(vec.exp_data));
    checkOutput({tag, "_parity_err"}, 32'(pe), 32'(vec.exp_pe));
    checkOutput({tag, "_frame_err"}, 32'(fe), 32'(vec.exp_fe));
    pulseReady(vec.idx);
    @(negedge clk);
    getOut(vec.idx, d, v, pe, fe, ov, b);
    checkOutput({tag, "_cleared"}, 32'({v, pe, fe, ov}), 32'd0);
  endtask

  initial begin
    logic [8:0] d, ed;
    logic v, pe, fe, ov, b, ok, seen, epe, efe;
    vec_t rv;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0};
    vecs[3] = '{2, 9'h003, 1'b1, 2'b11, 9'h003, 1'b0, 1'b0};
    vecs[4] = '{3, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
    vecs[5] = '{4, 9'h01F, 1'b0, 2'b11, 9'h01F, 1'b0, 1'b0};
    vecs[6] = '{0, 9'h05A, 1'b0, 2'b00, 9'h05A, 1'b0, 1'b1};
    vecs[7] = '{3, 9'h0C3, 1'b0, 2'b10, 9'h0C3, 1'b0, 1'b1};
    vecs[8] = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
    vecs[9] = '{4, 9'h03A, 1'b0, 2'b11, 9'h01A, 1'b0, 1'b0};

    rst_n  = 1'b0;
    bit_in = '1;
    ready  = '0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      getOut(i, d, v, pe, fe, ov, b);
      checkOutput($sformatf("reset_state_%0d", i), 32'({d, v, pe, fe, ov, b}), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] glitch on idle line");
    bit_in[0] = 1'b0;
    waitTicks(3);
    bit_in[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      getOut(0, d, v, pe, fe, ov, b);
      if (b) seen = 1'b1;
    end
    checkOutput("glitch_start_seen", 32'(seen), 32'd1);
    checkOutput("glitch_rejected", 32'({v, pe, fe, ov, b}), 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    @(posedge clk);
    checkOutput("busy_falls_before_valid", 32'({rise_cnt > 0, busy_rule_ok}), 32'd3);

    $display("[TB] overrun sequence");
    sendFrame(0, 9'h011, 1'b0, 2'b11, -1);
    waitValid(0, 2000, ok);
    checkOutput("ovr_first_valid", 32'(ok), 32'd1);
    sendFrame(0, 9'h022, 1'b0, 2'b11, -1);
    @(negedge clk);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("ovr_data_kept", 32'(d), 32'h011);
    checkOutput("ovr_flag_set", 32'({v, ov}), 32'd3);
    pulseReady(0);
    @(negedge clk);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("ovr_cleared", 32'({v, ov}), 32'd0);
    sendFrame(0, 9'h033, 1'b0, 2'b11, -1);
    waitValid(0, 2000, ok);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("ovr_next_data", 32'({ok, d, ov}), 32'({1'b1, 9'h033, 1'b0}));

    $display("[TB] reset in mid-frame");
    sendFrame(0, 9'h044, 1'b0, 2'b11, -1);
    sendFrame(0, 9'h055, 1'b0, 2'b11, 4);
    @(negedge clk);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("pre_reset_state", 32'({v, ov, b}), 32'd7);
    rst_n = 1'b0;
    #1;
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("async_reset_clears", 32'({d, v, pe, fe, ov, b}), 32'd0);
    bit_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitTicks(3 * OS);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("no_partial_word", 32'({v, b}), 32'd0);
    sendFrame(0, 9'h066, 1'b0, 2'b11, -1);
    waitValid(0, 2000, ok);
    getOut(0, d, v, pe, fe, ov, b);
    checkOutput("post_reset_frame", 32'({ok, d, pe, fe}), 32'({1'b1, 9'h066, 2'b00}));
    pulseReady(0);

    $display("[TB] random frames");
    for (int r = 0; r < 24; r++) begin
      rv.idx   = int'($urandom_range(0, 4));
      rv.data  = 9'($urandom);
      rv.par_b = 1'($urandom_range(0, 1));
      rv.stop  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      tick_div = int'($urandom_range(1, 3));
      refModel(rv.idx, rv.data, rv.par_b, rv.stop, ed, epe, efe);
      rv.exp_data = ed;
      rv.exp_pe   = epe;
      rv.exp_fe   = efe;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      applyStimulus(rv, $sformatf("rand%0d_rx%0d", r, rv.idx));
    end
    tick_div = 1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
